instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Instruction-side sequencer. It owns the PC, fetches 32-bit words from the instruction ROM over a req/ready handshake, and presents each word to the control decoder.
- It consumes the decoder's jump, branch and syscall outputs, plus datapath flags, to choose the next PC.
- It halts on a halting syscall and resumes on in_go.

Parameters:
- ADDR_W, 10, word-address width of instruction ROM (ROM depth 2^ADDR_W words)
- RESET_PC, 32'h0000_0000, PC loaded on reset (must be word-aligned)

Ports:
- in_clk  input  1  system clock, rising edge
- in_rst  input  1  reset, asynchronous, active-high
- in_go  input  1  start/resume pulse; sampled in IDLE and HALT
- out_mem_req  output  1  ROM read request
- out_mem_addr  output  ADDR_W  ROM word address = pc[ADDR_W+1:2]
- in_mem_ready  input  1  ROM data valid this cycle
- in_mem_data  input  32  ROM read data
- out_is  output  32  instruction word to decoder (in_is of decoder)
- out_is_valid  output  1  out_is valid, one cycle per instruction
- out_pc  output  32  PC of out_is
- out_pc4  output  32  out_pc + 4 (link value for JAL)
- in_J, in_JR, in_BEQ, in_BNE, in_BGEZ, in_syscall  input  1 each  decoder outputs for out_is
- in_equal  input  1  ALU rs==rt
- in_ge0  input  1  rs >= 0 (signed)
- in_rs_data  input  32  register rs value (JR target)
- in_halt_req  input  1  syscall is halting ($v0==10), qualified by in_syscall
- out_halted  output  1  high in HALT

Behaviour:
- All registers reset asynchronously on in_rst high:
  - pc = RESET_PC; state = IDLE.
  - out_is = 0, out_is_valid = 0, out_mem_req = 0, out_halted = 0.
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE: all outputs idle. On in_go go to FETCH.
- FETCH:
  - out_mem_req = 1 and out_mem_addr held stable until in_mem_ready.
  - On in_mem_ready, capture in_mem_data into out_is and go to ISSUE.
  - Minimum fetch latency is 1 cycle; ready may arrive any cycle later.
  - in_mem_ready while out_mem_req = 0 is ignored.
- ISSUE:
  - out_is_valid = 1 for exactly one cycle; the decoder flags are sampled in this same cycle (combinational decoder).
- Next-PC priority, evaluated in ISSUE:
  1. in_syscall & in_halt_req: pc <= pc+4, go to HALT.
  2. in_JR: pc <= in_rs_data.
  3. in_J: pc <= {pc4[31:28], out_is[25:0], 2'b00}.
  4. Branch taken, i.e. (in_BEQ&in_equal) | (in_BNE&~in_equal) | (in_BGEZ&in_ge0): pc <= pc4 + {{14{out_is[15]}}, out_is[15:0], 2'b00}.
  5. Otherwise pc <= pc4.
- After ISSUE (except the halting case) return to FETCH. Throughput is one instruction per 3 cycles with a ready ROM.
- Arithmetic:
  - All PC arithmetic is 32-bit modulo 2^32 and wraps silently (0xFFFF_FFFC + 4 = 0).
  - Address bits above ADDR_W+1 are not checked.
- JR target with bits[1:0] != 0: the low two bits are forced to 0 when loaded.
- Non-halting syscall: treated as a plain sequential instruction.
- HALT: out_halted = 1, no requests. in_go resumes into FETCH at the stored pc.
- in_go outside IDLE/HALT is ignored.
- Reset mid-fetch: req drops immediately (async). A late in_mem_ready after reset is ignored.

Optional Feature:
- Macro FETCH_STATS_EN.
- When defined, add two output ports:
  - out_insn_count [31:0]: increments on every ISSUE cycle.
  - out_taken_count [31:0]: increments on every ISSUE where cases 2–4 of the next-PC priority apply.
- Both counters reset to 0 on in_rst, wrap at 2^32, and freeze in HALT and IDLE.
- When undefined, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
- Reset, then in_go, with ROM always ready and holding words 0..3 = 0x2008_0001..4 (no flow control):
  - out_mem_addr sequence is 0, 1, 2, 3.
  - out_is_valid pulses every 3rd cycle.
  - out_pc values are 0, 4, 8, 12.
- BEQ at pc=0x10 with imm=0xFFFC and in_equal=1: next out_pc = 0x04. With in_equal=0, next out_pc = 0x14.
- J at pc=0x2000_0100 with index 0x0000040: next pc = 0x2000_0100. JR with in_rs_data=0x0000_0203: next pc = 0x0000_0200.
- ROM ready delayed 5 cycles:
  - out_mem_req stays high and out_mem_addr is stable for all 5 cycles.
  - A single out_is_valid pulse follows, carrying the delayed data.
- in_syscall=1 & in_halt_req=1 at pc=0x40:
  - out_halted = 1 and no further requests.
  - in_go pulse resumes with a fetch at address 0x44>>2 = 17.
- Assert in_rst while in FETCH: outputs return to reset values in the same cycle and state is IDLE. With FETCH_STATS_EN defined, both counters read 0.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Instruction ROM read port: word-addressed request with ready/data return.
// The fetch unit drives the master side; the ROM drives the slave side.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 10
);
  logic              out_mem_req;
  logic [ADDR_W-1:0] out_mem_addr;
  logic              in_mem_ready;
  logic [31:0]       in_mem_data;

  modport master (
    output out_mem_req,
    output out_mem_addr,
    input  in_mem_ready,
    input  in_mem_data
  );

  modport slave (
    input  out_mem_req,
    input  out_mem_addr,
    output in_mem_ready,
    output in_mem_data
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC sequencer: fetch from ROM, issue to decoder, pick next PC, halt/resume.
// Optional FETCH_STATS_EN adds issued/taken instruction counters.
module instr_fetch_unit #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_go,
  instr_fetch_unit_if.master mem,
  output logic [31:0] out_is,
  output logic        out_is_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4,
  input  logic        in_J,
  input  logic        in_JR,
  input  logic        in_BEQ,
  input  logic        in_BNE,
  input  logic        in_BGEZ,
  input  logic        in_syscall,
  input  logic        in_equal,
  input  logic        in_ge0,
  input  logic [31:0] in_rs_data,
  input  logic        in_halt_req,
  output logic        out_halted
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] out_insn_count,
  output logic [31:0] out_taken_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] is_q, is_d;
  logic        arm_q, arm_d;
  logic [31:0] pc4;
  logic [31:0] br_off;
  logic        accept;
  logic        br_taken;
  logic        taken;

  assign pc4      = pc_q + 32'd4;
  assign br_off   = {{14{is_q[15]}}, is_q[15:0], 2'b00};
  assign br_taken = (in_BEQ & in_equal) |
                    (in_BNE & ~in_equal) |
                    (in_BGEZ & in_ge0);
  // ROM is synchronous: ready counts only after req has been up a cycle.
  assign accept   = (state_q == FETCH) & arm_q & mem.in_mem_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    is_d    = is_q;
    arm_d   = 1'b0;
    taken   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_go) state_d = FETCH;
      end
      FETCH: begin
        if (accept) begin
          is_d    = mem.in_mem_data;
          state_d = ISSUE;
        end else begin
          arm_d = 1'b1;
        end
      end
      ISSUE: begin
        state_d = FETCH;
        if (in_syscall & in_halt_req) begin
          pc_d    = pc4;
          state_d = HALT;
        end else if (in_JR) begin
          pc_d  = in_rs_data & ~32'd3;
          taken = 1'b1;
        end else if (in_J) begin
          pc_d  = {pc4[31:28], is_q[25:0], 2'b00};
          taken = 1'b1;
        end else if (br_taken) begin
          pc_d  = pc4 + br_off;
          taken = 1'b1;
        end else begin
          pc_d = pc4;
        end
      end
      HALT: begin
        if (in_go) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      is_q    <= 32'd0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      is_q    <= is_d;
      arm_q   <= arm_d;
    end
  end

  assign mem.out_mem_req  = (state_q == FETCH);
  assign mem.out_mem_addr = pc_q[ADDR_W+1:2];
  assign out_is           = is_q;
  assign out_is_valid     = (state_q == ISSUE);
  assign out_pc           = pc_q;
  assign out_pc4          = pc4;
  assign out_halted       = (state_q == HALT);

`ifdef FETCH_STATS_EN
  logic [31:0] insn_q, insn_d;
  logic [31:0] tkn_q, tkn_d;

  always_comb begin
    insn_d = insn_q;
    tkn_d  = tkn_q;
    if (state_q == ISSUE) begin
      insn_d = insn_q + 32'd1;
      if (taken) tkn_d = tkn_q + 32'd1;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      insn_q <= 32'd0;
      tkn_q  <= 32'd0;
    end else begin
      insn_q <= insn_d;
      tkn_q  <= tkn_d;
    end
  end

  assign out_insn_count  = insn_q;
  assign out_taken_count = tkn_q;
`endif

endmodule
